// File: rtl/lin_resp_frame.sv
// LIN responder: serialises 1..MAX_BYTES data bytes plus a LIN checksum byte
// (classic or enhanced) after a commander header, each bit held BIT_DIV cycles.
// Optional build macro LIN_RESP_PARITY_CHECK_EN: reject starts whose PID parity
// bits are wrong.
module lin_resp_frame #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned BIT_DIV   = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             pid,
  input  logic [3:0]             data_len,
  input  logic                   enhanced,
  input  logic [8*MAX_BYTES-1:0] data,
  output logic                   sdo_resp,
  output logic                   resp_busy,
  output logic                   resp_tx_done,
  output logic [7:0]             checksum,
  output logic                   resp_err
);

  localparam int unsigned     CntW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(BIT_DIV - 1);
  localparam logic [3:0]      MaxLen    = 4'(MAX_BYTES);

  typedef enum logic [2:0] {StIdle, StStartBit, StDataBit, StStopBit, StDone} state_e;

  state_e                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [3:0]             len_q;
  logic [3:0]             byte_idx_q;  // bytes already loaded minus one; == len_q for checksum
  logic [2:0]             bit_idx_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [7:0]             shift_q;     // byte currently on the wire
  logic [7:0]             acc_q;
  logic [7:0]             checksum_q;
  logic                   err_q;

  logic       bit_end;
  logic       parity_ok;
  logic       accept;
  logic [3:0] len_eff;
  logic [3:0] byte_nxt;
  logic [7:0] acc_init;
  logic [7:0] nxt_byte;

  // 8-bit add with end-around carry
  function automatic logic [7:0] ones_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

`ifdef LIN_RESP_PARITY_CHECK_EN
  assign parity_ok = (pid[6] == (pid[0] ^ pid[1] ^ pid[2] ^ pid[4])) &&
                     (pid[7] == ~(pid[1] ^ pid[3] ^ pid[4] ^ pid[5]));
`else
  assign parity_ok = 1'b1;
`endif

  assign accept   = (data_len != 4'd0) && parity_ok;
  assign len_eff  = (data_len > MaxLen) ? MaxLen : data_len;
  assign acc_init = enhanced ? pid : 8'h00;
  assign bit_end  = (bit_cnt_q == '0);
  assign byte_nxt = byte_idx_q + 4'd1;

  // Select the next payload byte from the latched frame
  always_comb begin
    nxt_byte = 8'h00;
    for (int unsigned k = 0; k < MAX_BYTES; k++) begin
      if (byte_nxt == 4'(k)) nxt_byte = data_q[8*k +: 8];
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start && accept) state_d = StStartBit;
      StStartBit: if (bit_end) state_d = StDataBit;
      StDataBit:  if (bit_end && (bit_idx_q == 3'd7)) state_d = StStopBit;
      StStopBit:  if (bit_end) state_d = (byte_idx_q == len_q) ? StDone : StStartBit;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath: frame latch, bit timing, byte sequencing and checksum accumulation
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_q     <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (accept) begin
              data_q     <= data;
              len_q      <= len_eff;
              byte_idx_q <= '0;
              bit_idx_q  <= '0;
              bit_cnt_q  <= CntReload;
              shift_q    <= data[7:0];
              acc_q      <= ones_add(acc_init, data[7:0]);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StStartBit, StDataBit, StStopBit: begin
          bit_cnt_q <= bit_end ? CntReload : bit_cnt_q - CntW'(1);
          if (bit_end && (state_q == StDataBit)) bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_end && (state_q == StStopBit)) begin
            if (byte_nxt < len_q) begin
              byte_idx_q <= byte_nxt;
              shift_q    <= nxt_byte;
              acc_q      <= ones_add(acc_q, nxt_byte);
            end else if (byte_nxt == len_q) begin
              // Checksum byte goes out next; publish it as it starts
              byte_idx_q <= byte_nxt;
              shift_q    <= ~acc_q;
              checksum_q <= ~acc_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    sdo_resp     = 1'b1;
    resp_busy    = 1'b0;
    resp_tx_done = 1'b0;
    case (state_q)
      StStartBit: begin
        sdo_resp  = 1'b0;
        resp_busy = 1'b1;
      end
      StDataBit: begin
        sdo_resp  = shift_q[bit_idx_q];
        resp_busy = 1'b1;
      end
      StStopBit: resp_busy = 1'b1;
      StDone:    resp_tx_done = 1'b1;
      default: ;
    endcase
  end

  assign checksum = checksum_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_lin_resp_frame.sv
// Self-checking bench for lin_resp_frame: a BIT_DIV=1 and a BIT_DIV=4 instance
// checked cycle by cycle against a bit-queue model of the LIN response frame.
module tb_lin_resp_frame;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [7:0]  pid;
  logic [3:0]  data_len;
  logic        enhanced;
  logic [63:0] data;

  logic        sdo1, busy1, done1, err1;
  logic [7:0]  chk1;
  logic        sdo4, busy4, done4, err4;
  logic [7:0]  chk4;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  lin_resp_frame #(.MAX_BYTES(8), .BIT_DIV(1)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start1), .pid(pid), .data_len(data_len),
    .enhanced(enhanced), .data(data), .sdo_resp(sdo1), .resp_busy(busy1),
    .resp_tx_done(done1), .checksum(chk1), .resp_err(err1)
  );

  lin_resp_frame #(.MAX_BYTES(8), .BIT_DIV(4)) dut4 (
    .sys_clk(sys_clk), .rst(rst), .start(start4), .pid(pid), .data_len(data_len),
    .enhanced(enhanced), .data(data), .sdo_resp(sdo4), .resp_busy(busy4),
    .resp_tx_done(done4), .checksum(chk4), .resp_err(err4)
  );

  function automatic logic [7:0] make_pid(input logic [5:0] id);
    logic p0, p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  // Ones-complement sum of all bytes (plus PID if enhanced), inverted
  function automatic logic [7:0] model_chk(input logic [63:0] d, input int n, input bit enh,
                                           input logic [7:0] p);
    int sum;
    logic [7:0] r;
    sum = enh ? int'(p) : 0;
    for (int i = 0; i < n; i++) sum += int'(d[8*i +: 8]);
    while (sum > 255) sum = (sum & 255) + (sum >> 8);
    r = sum[7:0];
    return ~r;
  endfunction

  task automatic drive_start(input bit slow, input logic v);
    if (slow) start4 = v;
    else      start1 = v;
  endtask

  // One-cycle start pulse; returns at the negedge of the first frame cycle
  task automatic launch(input bit slow);
    @(negedge sys_clk);
    drive_start(slow, 1'b1);
    @(negedge sys_clk);
    drive_start(slow, 1'b0);
  endtask

  task automatic check_frame(input bit slow, input bit chain, input bit poke,
                             input logic [63:0] d, input logic [3:0] len, input bit enh,
                             input logic [7:0] p);
    int n, div, len_cycles, chk_from;
    logic [7:0] exp_chk, cur;
    bit q[$];
    logic o_sdo, o_busy, o_done;
    logic [7:0] o_chk;
    n = (len > 4'd8) ? 8 : int'(len);
    div = slow ? 4 : 1;
    len_cycles = 10 * (n + 1) * div;
    chk_from = 10 * n * div + 1;
    exp_chk = model_chk(d, n, enh, p);
    for (int b = 0; b <= n; b++) begin
      cur = (b < n) ? d[8*b +: 8] : exp_chk;
      q.push_back(1'b0);
      for (int j = 0; j < 8; j++) q.push_back(cur[j]);
      q.push_back(1'b1);
    end
    for (int k = 1; k <= len_cycles + 1; k++) begin
      o_sdo  = slow ? sdo4 : sdo1;
      o_busy = slow ? busy4 : busy1;
      o_done = slow ? done4 : done1;
      o_chk  = slow ? chk4 : chk1;
      if (k <= len_cycles) begin
        checks++;
        if (o_sdo !== q[(k-1)/div]) begin
          failures++;
          $display("FAIL sdo_bit cycle=%0d got=%b exp=%b", k, o_sdo, q[(k-1)/div]);
        end
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
          failures++;
          $display("FAIL busy_in_frame cycle=%0d got busy=%b done=%b exp busy=1 done=0",
                   k, o_busy, o_done);
        end
      end else begin
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_sdo !== 1'b1) begin
          failures++;
          $display("FAIL frame_end cycle=%0d got done=%b busy=%b sdo=%b exp 1 0 1",
                   k, o_done, o_busy, o_sdo);
        end
      end
      if (k >= chk_from) begin
        checks++;
        if (o_chk !== exp_chk) begin
          failures++;
          $display("FAIL checksum cycle=%0d got=%02h exp=%02h", k, o_chk, exp_chk);
        end
      end
      if (poke && k == 12) begin
        drive_start(slow, 1'b1);
        data = ~d;
        data_len = 4'd3;
        enhanced = !enh;
      end
      if (poke && k == 13) drive_start(slow, 1'b0);
      if (chain && k == len_cycles + 1) drive_start(slow, 1'b1);
      @(negedge sys_clk);
    end
    o_busy = slow ? busy4 : busy1;
    o_done = slow ? done4 : done1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done got busy=%b done=%b exp 0 0", o_busy, o_done);
    end
    if (chain) begin
      @(negedge sys_clk);
      drive_start(slow, 1'b0);
    end
  endtask

  task automatic run(input bit slow, input logic [63:0] d, input logic [3:0] len,
                     input bit enh, input logic [7:0] p);
    data = d;
    data_len = len;
    enhanced = enh;
    pid = p;
    launch(slow);
    check_frame(slow, 1'b0, 1'b0, d, len, enh, p);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    checks++; if (sdo1 !== 1'b1) begin failures++; $display("FAIL rst_sdo got=%b exp=1", sdo1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done1); end
    checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err1); end
    checks++; if (chk1 !== 8'h00) begin failures++; $display("FAIL rst_chk got=%02h exp=00", chk1); end
    checks++; if (sdo4 !== 1'b1) begin failures++; $display("FAIL rst_sdo4 got=%b exp=1", sdo4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy4 got=%b exp=0", busy4); end
    checks++; if (chk4 !== 8'h00) begin failures++; $display("FAIL rst_chk4 got=%02h exp=00", chk4); end
  endtask

  task automatic test_classic();
    run(1'b0, 64'hE5_93_55_4A, 4'd4, 1'b0, 8'h50);
    checks++;
    if (chk1 !== 8'hE6) begin failures++; $display("FAIL classic_chk got=%02h exp=E6", chk1); end
  endtask

  task automatic test_enhanced();
    run(1'b0, 64'hE5_93_55_4A, 4'd4, 1'b1, 8'h50);
    checks++;
    if (chk1 !== 8'h96) begin failures++; $display("FAIL enhanced_chk got=%02h exp=96", chk1); end
  endtask

  task automatic test_carry();
    run(1'b0, 64'hFF_FF, 4'd2, 1'b0, 8'h50);
    checks++;
    if (chk1 !== 8'h00) begin failures++; $display("FAIL carry2_chk got=%02h exp=00", chk1); end
    run(1'b0, 64'h96_FF, 4'd1, 1'b0, 8'h50);
    checks++;
    if (chk1 !== 8'h00) begin failures++; $display("FAIL carry1_chk got=%02h exp=00", chk1); end
  endtask

  task automatic test_bit_div();
    run(1'b1, 64'hA5, 4'd1, 1'b0, 8'h50);
    run(1'b1, {$urandom, $urandom}, 4'($urandom_range(1, 3)), 1'b1, make_pid(6'($urandom)));
  endtask

  task automatic test_clamp();
    run(1'b0, {$urandom, $urandom}, 4'd9, 1'($urandom), make_pid(6'($urandom)));
    run(1'b0, {$urandom, $urandom}, 4'd15, 1'b1, make_pid(6'($urandom)));
  endtask

  task automatic test_reject();
    data = {$urandom, $urandom};
    data_len = 4'd0;
    enhanced = 1'b0;
    pid = 8'h50;
    launch(1'b0);
    checks++;
    if (err1 !== 1'b1 || busy1 !== 1'b0 || sdo1 !== 1'b1) begin
      failures++;
      $display("FAIL len0_reject got err=%b busy=%b sdo=%b exp 1 0 1", err1, busy1, sdo1);
    end
    @(negedge sys_clk);
    checks++;
    if (err1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL len0_after got err=%b busy=%b exp 0 0", err1, busy1);
    end
    data_len = 4'd2;
    pid = 8'h10;
    launch(1'b0);
`ifdef LIN_RESP_PARITY_CHECK_EN
    checks++;
    if (err1 !== 1'b1 || busy1 !== 1'b0 || sdo1 !== 1'b1) begin
      failures++;
      $display("FAIL parity_reject got err=%b busy=%b sdo=%b exp 1 0 1", err1, busy1, sdo1);
    end
    @(negedge sys_clk);
`else
    checks++;
    if (err1 !== 1'b0) begin failures++; $display("FAIL pid_unchecked got err=%b exp=0", err1); end
    check_frame(1'b0, 1'b0, 1'b0, data, 4'd2, 1'b0, 8'h10);
`endif
    run(1'b0, {$urandom, $urandom}, 4'd2, 1'b1, 8'h50);
  endtask

  task automatic test_busy_ignore();
    logic [63:0] d;
    logic [7:0] p;
    d = {$urandom, $urandom};
    p = make_pid(6'($urandom));
    data = d;
    data_len = 4'd3;
    enhanced = 1'b1;
    pid = p;
    launch(1'b0);
    check_frame(1'b0, 1'b0, 1'b1, d, 4'd3, 1'b1, p);
  endtask

  task automatic test_rst_mid();
    bit bad;
    data = {$urandom, $urandom};
    data_len = 4'd4;
    enhanced = 1'b0;
    pid = 8'h50;
    launch(1'b0);
    repeat (14) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    checks++;
    if (sdo1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || chk1 !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid got sdo=%b busy=%b done=%b chk=%02h exp 1 0 0 00",
               sdo1, busy1, done1, chk1);
    end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy1 !== 1'b0 || done1 !== 1'b0) bad = 1'b1;
      @(negedge sys_clk);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL rst_abandon got activity=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] da, db;
    logic [7:0] pa, pb;
    logic [3:0] la, lb;
    bit ea, eb;
    da = {$urandom, $urandom}; la = 4'($urandom_range(1, 4)); ea = 1'($urandom);
    pa = make_pid(6'($urandom));
    db = {$urandom, $urandom}; lb = 4'($urandom_range(1, 4)); eb = 1'($urandom);
    pb = make_pid(6'($urandom));
    data = da; data_len = la; enhanced = ea; pid = pa;
    launch(1'b0);
    data = db; data_len = lb; enhanced = eb; pid = pb;
    check_frame(1'b0, 1'b1, 1'b0, da, la, ea, pa);
    check_frame(1'b0, 1'b0, 1'b0, db, lb, eb, pb);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run(($urandom_range(0, 3) == 0), {$urandom, $urandom}, 4'($urandom_range(1, 10)),
          1'($urandom), make_pid(6'($urandom)));
    end
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    pid = 8'h50;
    data_len = 4'd1;
    enhanced = 1'b0;
    data = '0;
    test_reset();
    test_classic();
    test_enhanced();
    test_carry();
    test_bit_div();
    test_clamp();
    test_reject();
    test_busy_ignore();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lin_resp_frame.md
# lin_resp_frame

Parametrised LIN responder that serialises a variable-length response frame (1..MAX_BYTES data bytes plus checksum) onto the bus after the commander finishes a header. It generalises the fixed 8-byte responder in three ways: a runtime byte count, a configurable bit period, and selectable LIN classic or enhanced checksum in place of a fixed CRC. It sits between the commander header logic and the LIN PHY driver.

## Interface
- MAX_BYTES, 8, maximum data bytes per response (1..8)
- BIT_DIV, 1, sys_clk cycles per LIN bit (>=1)

- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  header-complete pulse from commander; accepted only in IDLE
- pid  in  8  protected identifier {P1,P0,ID[5:0]} of the current header
- data_len  in  4  number of data bytes to send
- enhanced  in  1  1 = enhanced checksum (PID included), 0 = classic
- data  in  8*MAX_BYTES  payload; byte k = data[8k+7:8k], byte 0 sent first
- sdo_resp  out  1  serial data out, idle/recessive = 1
- resp_busy  out  1  high from accepted start until frame end
- resp_tx_done  out  1  one-cycle pulse at frame end
- checksum  out  8  checksum of last frame
- resp_err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, START_BIT, DATA_BIT, STOP_BIT, DONE.
- IDLE: sdo_resp=1. On start=1: latch data, pid, enhanced, length; init accumulator to pid (enhanced) or 0 (classic); go START_BIT. start ignored in any other state.
- data_len==0: reject, resp_err pulse, stay IDLE. data_len>MAX_BYTES: clamp to MAX_BYTES.
- Each byte framed: START_BIT (0), DATA_BIT x8 LSB first, STOP_BIT (1). Bytes 0..N-1, then checksum byte with identical framing.
- Accumulator: on loading each data byte, s = acc + byte (9 bits); acc = s[7:0] + s[8] (end-around carry). Checksum = ~acc, latched when checksum byte loads.
- After checksum stop bit: DONE for one cycle, resp_tx_done=1, resp_busy=0, return IDLE.
- Total line time = 10*(N+1)*BIT_DIV cycles.

## Timing
- Reset values: sdo_resp=1, resp_busy=0, resp_tx_done=0, resp_err=0, checksum=0, state IDLE.
- start sampled at edge T; resp_busy=1 and sdo_resp=0 (first start bit) from T+1.
- Each bit held exactly BIT_DIV cycles via down-counter; bit index and byte index advance on counter expiry.
- checksum output valid from the cycle the checksum byte's start bit drives; held until next accepted start.
- resp_tx_done and resp_busy deassertion occur in the same cycle, BIT_DIV cycles after last stop bit begins.
- start in DONE cycle is ignored; start in the IDLE cycle following DONE is accepted.
- rst mid-frame: next edge forces reset values; partial frame abandoned, no done pulse.
- BIT_DIV=1: no idle cycles between bits; byte boundaries add no gaps.

## Configuration
- LIN_RESP_PARITY_CHECK_EN defined: on start, P0 = ID0^ID1^ID2^ID4 and P1 = ~(ID1^ID3^ID4^ID5) are checked against pid[6], pid[7]; mismatch rejects the start (resp_err pulse, stays IDLE, sdo_resp=1).
- Undefined: pid used unchecked; resp_err driven only by data_len==0.

## Test plan
- Classic, BIT_DIV=1, data_len=4, bytes 0x4A,0x55,0x93,0xE5 -> 50-bit stream, checksum=0xE6, resp_tx_done 51 cycles after start.
- Enhanced, pid=0x50, same bytes -> checksum=0x96; serial checksum byte LSB-first 0,1,1,0,1,0,0,1.
- Carry wrap: classic, bytes 0xFF,0xFF -> checksum=0x00; single byte 0xFF -> 0x00.
- BIT_DIV=4, data_len=1, byte 0xA5 -> each bit held 4 cycles, frame 80 cycles; data_len=9 with MAX_BYTES=8 -> 8 bytes sent.
- data_len=0 -> resp_err pulse, resp_busy stays 0; with LIN_RESP_PARITY_CHECK_EN, pid=0x10 -> resp_err, pid=0x50 -> accepted.
- rst asserted at bit 15 of a 4-byte frame -> next cycle sdo_resp=1, resp_busy=0, no resp_tx_done; start while busy ignored.
